// File: rtl/cpu_packet_tx.sv
// rtl/cpu_packet_tx.sv - CPU-composed Ethernet frame buffer replayed as a framed byte stream with padding.
// Optional FCS generation is enabled by defining CPU_PACKET_TX_FCS_EN.
module cpu_packet_tx #(
    parameter int DEPTH_LOG2 = 11,
    parameter int MIN_LEN    = 60
) (
    input  logic       clk_cpu,
    input  logic       clk_cpu_reset_n,
    input  logic [7:0] eth_tx_data,
    input  logic       eth_tx_write,
    input  logic       eth_tx_commit,
    output logic       eth_tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_sof,
    output logic       tx_eof,
    input  logic       tx_ready,
    output logic [7:0] tx_drop_count
);

    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] MIN_W = (AW+1)'(MIN_LEN);

    typedef enum logic [1:0] {
        S_FILL,
        S_SEND,
        S_PAD
`ifdef CPU_PACKET_TX_FCS_EN
        , S_FCS
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic        ovf_q, ovf_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] idx_q, idx_d;
    logic        primed_q, primed_d;
    logic        done_q, done_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_sof_q, tx_sof_d;
    logic        tx_eof_q, tx_eof_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  rd_data_q;
    logic [7:0]  mem [0:(1<<AW)-1];

    logic        mem_we;
    logic [AW:0] wr_ptr_nx;
    logic        ovf_nx;
    logic [AW:0] idx_inc;
    logic        load;
    logic [7:0]  load_byte;

`ifdef CPU_PACKET_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [1:0]  fcs_cnt_q, fcs_cnt_d;
    logic [31:0] crc_fin;

    // Reflected CRC-32 (0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign crc_fin = ~crc_q;
`endif

    always_comb begin
        load_byte = 8'h00;
        case (state_q)
            S_SEND:  load_byte = rd_data_q;
`ifdef CPU_PACKET_TX_FCS_EN
            S_FCS:   load_byte = crc_fin[{fcs_cnt_q, 3'b000} +: 8];
`endif
            default: load_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        len_d      = len_q;
        idx_d      = idx_q;
        primed_d   = primed_q;
        done_d     = done_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sof_d   = tx_sof_q;
        tx_eof_d   = tx_eof_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        wr_ptr_nx  = wr_ptr_q;
        ovf_nx     = ovf_q;
        idx_inc    = idx_q + 1'b1;
        load       = primed_q & ~done_q & (~tx_valid_q | tx_ready);
`ifdef CPU_PACKET_TX_FCS_EN
        crc_d      = crc_q;
        fcs_cnt_d  = fcs_cnt_q;
`endif
        case (state_q)
            S_FILL: begin
                // A write in the commit cycle lands first so it belongs to the frame.
                if (eth_tx_write) begin
                    if (wr_ptr_q[AW]) begin
                        ovf_nx = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        wr_ptr_nx = wr_ptr_q + 1'b1;
                    end
                end
                wr_ptr_d = wr_ptr_nx;
                ovf_d    = ovf_nx;
                if (eth_tx_commit && (wr_ptr_nx != '0)) begin
                    if (ovf_nx) begin
                        wr_ptr_d = '0;
                        ovf_d    = 1'b0;
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        len_d    = wr_ptr_nx;
                        idx_d    = '0;
                        primed_d = 1'b0;
                        done_d   = 1'b0;
                        state_d  = S_SEND;
`ifdef CPU_PACKET_TX_FCS_EN
                        crc_d     = 32'hFFFF_FFFF;
                        fcs_cnt_d = 2'd0;
`endif
                    end
                end
            end
            default: begin
                // First cycle after commit only primes the RAM read of byte 0.
                primed_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_sof_d   = 1'b0;
                    tx_eof_d   = 1'b0;
                    if (tx_eof_q) begin
                        state_d  = S_FILL;
                        wr_ptr_d = '0;
                    end
                end
                if (load) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = load_byte;
                    tx_sof_d   = (state_q == S_SEND) && (idx_q == '0);
                    tx_eof_d   = 1'b0;
`ifdef CPU_PACKET_TX_FCS_EN
                    if (state_q == S_FCS) begin
                        fcs_cnt_d = fcs_cnt_q + 2'd1;
                        if (fcs_cnt_q == 2'd3) begin
                            tx_eof_d = 1'b1;
                            done_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                        crc_d = crc32_byte(crc_q, load_byte);
                        if ((idx_inc >= len_q) && (idx_inc >= MIN_W)) state_d = S_FCS;
                        else if (idx_inc >= len_q)                    state_d = S_PAD;
                    end
`else
                    idx_d = idx_inc;
                    if ((idx_inc >= len_q) && (idx_inc >= MIN_W)) begin
                        tx_eof_d = 1'b1;
                        done_d   = 1'b1;
                    end else if (idx_inc >= len_q) begin
                        state_d = S_PAD;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_cpu or negedge clk_cpu_reset_n) begin
        if (!clk_cpu_reset_n) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            primed_q   <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
            drop_q     <= 8'h00;
`ifdef CPU_PACKET_TX_FCS_EN
            crc_q      <= 32'hFFFF_FFFF;
            fcs_cnt_q  <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            ovf_q      <= ovf_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            primed_q   <= primed_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sof_q   <= tx_sof_d;
            tx_eof_q   <= tx_eof_d;
            drop_q     <= drop_d;
`ifdef CPU_PACKET_TX_FCS_EN
            crc_q      <= crc_d;
            fcs_cnt_q  <= fcs_cnt_d;
`endif
        end
    end

    // Read address follows the next index so rd_data_q always holds the byte due next.
    always_ff @(posedge clk_cpu) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= eth_tx_data;
        rd_data_q <= mem[idx_d[AW-1:0]];
    end

    assign eth_tx_ready  = (state_q == S_FILL);
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign tx_sof        = tx_sof_q;
    assign tx_eof        = tx_eof_q;
    assign tx_drop_count = drop_q;

endmodule

// File: tb/tb_cpu_packet_tx.sv
// tb/tb_cpu_packet_tx.sv - table-driven and directed checks of cpu_packet_tx framing, padding, FCS and corner cases.
module tb_cpu_packet_tx;

    logic       clk_cpu = 1'b0;
    logic       clk_cpu_reset_n = 1'b0;
    logic [7:0] eth_tx_data = 8'h00;
    logic       eth_tx_write = 1'b0;
    logic       eth_tx_commit = 1'b0;
    logic       eth_tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_sof;
    logic       tx_eof;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_drop_count;

    int checks = 0;
    int failures = 0;

`ifdef CPU_PACKET_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
    localparam int SHORT_TOTAL = 64;
`else
    localparam bit FCS_ON = 1'b0;
    localparam int SHORT_TOTAL = 60;
`endif

    cpu_packet_tx dut (
        .clk_cpu         (clk_cpu),
        .clk_cpu_reset_n (clk_cpu_reset_n),
        .eth_tx_data     (eth_tx_data),
        .eth_tx_write    (eth_tx_write),
        .eth_tx_commit   (eth_tx_commit),
        .eth_tx_ready    (eth_tx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_sof          (tx_sof),
        .tx_eof          (tx_eof),
        .tx_ready        (tx_ready),
        .tx_drop_count   (tx_drop_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        string      name;
        int         len;
        logic [7:0] base;
        bit         toggle;
        bit         same_cyc;
        int         exp_on;
        int         exp_off;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            c = c ^ {24'h0, q[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic write_frame(input int len, input logic [7:0] base, input bit same_cyc);
        for (int i = 0; i < len; i++) begin
            eth_tx_data   = base + 8'(i);
            eth_tx_write  = 1'b1;
            eth_tx_commit = same_cyc && (i == len - 1);
            tick();
        end
        eth_tx_write  = 1'b0;
        eth_tx_commit = 1'b0;
        if (!same_cyc) begin
            eth_tx_commit = 1'b1;
            tick();
            eth_tx_commit = 1'b0;
        end
    endtask

    // Entered just after the commit edge; collects one frame and checks it against the model.
    task automatic collect_frame(input string name, input int len, input logic [7:0] base,
                                 input bit toggle, input bit junk, input int exp_total);
        logic [7:0]  exp_q[$];
        logic [31:0] fcs;
        logic [10:0] prev;
        bit          prev_stall = 1'b0;
        bit          started = 1'b0;
        bit          done = 1'b0;
        bit          rdy;
        int          got = 0;
        int          first_valid = -1;
        int          budget = 3 * exp_total + 20;
        int          cyc = 0;

        for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(i));
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
        if (FCS_ON) begin
            fcs = crc_ref(exp_q);
            for (int b = 0; b < 4; b++) exp_q.push_back(fcs[8*b +: 8]);
        end

        check({name, "_ready_drop"}, eth_tx_ready, 1'b0);
        prev = '0;
        while (!done && cyc < budget) begin
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (started) check({name, "_valid_hold"}, tx_valid, 1'b1);
            if (prev_stall) check({name, "_stall_stable"}, {tx_valid, tx_sof, tx_eof, tx_data}, prev);
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            tx_ready = rdy;
            if (junk) begin
                eth_tx_write  = 1'b1;
                eth_tx_data   = 8'hAA;
                eth_tx_commit = (cyc % 7 == 3);
            end
            if (tx_valid) started = 1'b1;
            if (tx_valid && rdy) begin
                if (got < exp_q.size()) check({name, "_data"}, tx_data, exp_q[got]);
                check({name, "_sof"}, tx_sof, got == 0);
                check({name, "_eof"}, tx_eof, got == exp_total - 1);
                got++;
                if (tx_eof) done = 1'b1;
            end
            prev_stall = tx_valid && !rdy;
            prev = {tx_valid, tx_sof, tx_eof, tx_data};
            tick();
            cyc++;
        end
        eth_tx_write  = 1'b0;
        eth_tx_commit = 1'b0;
        tx_ready      = 1'b0;
        check({name, "_eof_seen"}, done, 1'b1);
        check({name, "_count"}, got, exp_total);
        check({name, "_latency"}, (first_valid >= 0) && (first_valid <= 2), 1'b1);
        check({name, "_ready_back"}, eth_tx_ready, 1'b1);
        check({name, "_idle_valid"}, tx_valid, 1'b0);
    endtask

    task automatic run_frame(input string name, input int len, input logic [7:0] base,
                             input bit toggle, input bit same_cyc, input bit junk, input int exp_total);
        write_frame(len, base, same_cyc);
        collect_frame(name, len, base, toggle, junk, exp_total);
    endtask

    task automatic expect_silence(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_valid) seen = 1'b1;
            tick();
        end
        check({name, "_no_valid"}, seen, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"min10",        10, 8'h01, 1'b0, 1'b0, 64,  60});
        vecs.push_back('{"len100_toggle", 100, 8'h10, 1'b1, 1'b0, 104, 100});
        vecs.push_back('{"len60_exact",  60, 8'h80, 1'b0, 1'b0, 64,  60});
        vecs.push_back('{"len59_same",   59, 8'h05, 1'b1, 1'b1, 64,  60});
        vecs.push_back('{"len1_same",     1, 8'hC3, 1'b0, 1'b1, 64,  60});
        vecs.push_back('{"len61",        61, 8'h20, 1'b0, 1'b0, 65,  61});

        tick();
        check("rst_valid", tx_valid, 1'b0);
        check("rst_sof", tx_sof, 1'b0);
        check("rst_eof", tx_eof, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_drop", tx_drop_count, 8'h00);
        check("rst_ready", eth_tx_ready, 1'b1);
        tick();
        clk_cpu_reset_n = 1'b1;
        tick();

        foreach (vecs[v])
            run_frame(vecs[v].name, vecs[v].len, vecs[v].base, vecs[v].toggle, vecs[v].same_cyc,
                      1'b0, FCS_ON ? vecs[v].exp_on : vecs[v].exp_off);

        eth_tx_commit = 1'b1;
        tick();
        eth_tx_commit = 1'b0;
        check("zero_commit_ready", eth_tx_ready, 1'b1);
        expect_silence("zero_commit", 6);

        for (int i = 0; i < 2049; i++) begin
            eth_tx_data  = 8'(i);
            eth_tx_write = 1'b1;
            tick();
        end
        eth_tx_write  = 1'b0;
        eth_tx_commit = 1'b1;
        tick();
        eth_tx_commit = 1'b0;
        check("ovf_ready", eth_tx_ready, 1'b1);
        expect_silence("ovf", 6);
        check("ovf_drop", tx_drop_count, 8'd1);
        run_frame("after_ovf", 60, 8'h40, 1'b0, 1'b0, 1'b0, SHORT_TOTAL);

        run_frame("junk_send", 20, 8'h30, 1'b0, 1'b0, 1'b1, SHORT_TOTAL);
        run_frame("after_junk", 5, 8'h50, 1'b0, 1'b0, 1'b0, SHORT_TOTAL);

        begin
            int got = 0;
            int cyc = 0;
            bit hit = 1'b0;
            write_frame(30, 8'h60, 1'b0);
            tx_ready = 1'b1;
            while (!hit && cyc < 60) begin
                if (tx_valid && got == 20) hit = 1'b1;
                else begin
                    if (tx_valid) got++;
                    tick();
                    cyc++;
                end
            end
            check("abort_reached", hit, 1'b1);
            check("abort_byte20", tx_data, 8'h74);
            #2;
            clk_cpu_reset_n = 1'b0;
            #1;
            check("abort_valid", tx_valid, 1'b0);
            check("abort_sof", tx_sof, 1'b0);
            check("abort_eof", tx_eof, 1'b0);
            check("abort_ready", eth_tx_ready, 1'b1);
            check("abort_drop", tx_drop_count, 8'h00);
            tx_ready = 1'b0;
            tick();
            clk_cpu_reset_n = 1'b1;
            tick();
            run_frame("after_abort", 10, 8'h01, 1'b0, 1'b0, 1'b0, SHORT_TOTAL);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
